// File: rtl/msr_pkg.sv
// Shared types for the multimode shift register: mode encoding, serializer states,
// and the shift-amount width helper.
package msr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_SAR  = 3'b110,
    MODE_SER  = 3'b111
  } msr_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } msr_state_e;

  function automatic int msr_aw(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/msr_shift_core.sv
// Combinational barrel shifter producing next-q for the shift/rotate modes; other modes pass q through.
// Rotate paths exist only when MSR_ROTATE_EN is defined, otherwise rotate modes hold.
module msr_shift_core
  import msr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = msr_aw(WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic [AW-1:0]    amt_i,
  input  logic             fill_left_i,
  input  logic             fill_right_i,
  output logic [WIDTH-1:0] next_q_o
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [AW-1:0]    sh;
  logic [WIDTH-1:0] rmask;
  logic [WIDTH-1:0] lmask;

  // Non-power-of-two widths can present amounts past WIDTH-1; fold them back.
  assign sh    = AW'(32'(amt_i) % 32'(WIDTH));
  assign rmask = ONES >> sh;
  assign lmask = ONES << sh;

`ifdef MSR_ROTATE_EN
  logic [31:0] rsh;
  assign rsh = 32'(WIDTH) - 32'(sh);
`endif

  always_comb begin
    next_q_o = q_i;
    case (msr_mode_e'(mode_i))
      MODE_SHR: next_q_o = (q_i >> sh) | (fill_left_i  ? ~rmask : '0);
      MODE_SHL: next_q_o = (q_i << sh) | (fill_right_i ? ~lmask : '0);
      MODE_SAR: next_q_o = (q_i >> sh) | (q_i[WIDTH-1] ? ~rmask : '0);
`ifdef MSR_ROTATE_EN
      MODE_ROR: next_q_o = (q_i >> sh) | (q_i << rsh);
      MODE_ROL: next_q_o = (q_i << sh) | (q_i >> rsh);
`endif
      default:  next_q_o = q_i;
    endcase
  end

endmodule

// File: rtl/multimode_shift_reg.sv
// Shift/rotate/load register with an LSB-first serializer; ops take effect on the next edge, serializer runs WIDTH cycles.
// Rotate modes 100/101 are enabled by MSR_ROTATE_EN; without it they hold.
module multimode_shift_reg
  import msr_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int AW    = msr_aw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  msr_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, core_q;
  logic [AW-1:0]    cnt_q, cnt_d;

  msr_shift_core #(.WIDTH(WIDTH), .AW(AW)) u_core (
    .q_i          (q_q),
    .mode_i       (mode),
    .amt_i        (amt),
    .fill_left_i  (serial_in_left),
    .fill_right_i (serial_in_right),
    .next_q_o     (core_q)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_SER) begin
          q_d     = parallel_in;
          cnt_d   = AW'(WIDTH - 1);
          state_d = ST_XFER;
        end else if (mode == MODE_LOAD) begin
          q_d = parallel_in;
        end else begin
          q_d = core_q;
        end
      end
      ST_XFER: begin
        // Inputs other than the left fill bit are ignored until the last bit leaves.
        q_d = {serial_in_left, q_q[WIDTH-1:1]};
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q          = q_q;
  assign serial_out = q_q[0];
  assign busy       = (state_q == ST_XFER);
  assign done       = (state_q == ST_XFER) && (cnt_q == '0);

endmodule

// File: tb/tb_multimode_shift_reg.sv
// Self-checking bench for multimode_shift_reg (WIDTH=8): directed vectors, serializer/reset sequences,
// and randomized traffic against a bit-index reference model. Honours MSR_ROTATE_EN for rotate expectations.
module tb_multimode_shift_reg;

  localparam int W = 8;
`ifdef MSR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  localparam logic [2:0] M_HOLD = 3'b000, M_SHR = 3'b001, M_SHL = 3'b010, M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100, M_ROL = 3'b101, M_SAR = 3'b110, M_SER = 3'b111;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   mode;
  logic [2:0]   amt;
  logic         sil, sir;
  logic [W-1:0] pin;
  logic [W-1:0] q;
  logic         serial_out, busy, done;

  int tests = 0;
  int fails = 0;

  multimode_shift_reg #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode            (mode),
    .amt             (amt),
    .serial_in_left  (sil),
    .serial_in_right (sir),
    .parallel_in     (pin),
    .q               (q),
    .serial_out      (serial_out),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]   mode;
    logic [2:0]   amt;
    logic         sil;
    logic         sir;
    logic [W-1:0] pin;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each result bit is picked from its source index by the operation's definition.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] v, input logic [2:0] m, input int a_in,
                                          input logic fl, input logic fr);
    logic [W-1:0] r;
    int a;
    r = v;
    a = a_in % W;
    for (int i = 0; i < W; i++) begin
      case (m)
        M_SHR: r[i] = (i + a < W) ? v[i + a] : fl;
        M_SHL: r[i] = (i - a >= 0) ? v[i - a] : fr;
        M_SAR: r[i] = (i + a < W) ? v[i + a] : v[W-1];
        M_ROR: if (ROT) r[i] = v[(i + a) % W];
        M_ROL: if (ROT) r[i] = v[(i - a + W) % W];
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic serialize(input string tag, input logic [W-1:0] data, input int nbits_before_stop);
    mode = M_SER; pin = data; sil = 1'b0;
    step();
    mode = M_LOAD; pin = 8'hFF;  // must be ignored while busy
    for (int k = 0; k < nbits_before_stop; k++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " sout"}, 64'(serial_out), 64'(data[k]));
      check({tag, " done"}, 64'(done), 64'(k == W - 1));
      if (k != nbits_before_stop - 1 || nbits_before_stop == W) step();
    end
  endtask

  logic [W-1:0] mq;
  int           bits_left;
  logic         exp_done;

  initial begin
    reset_n = 1'b0; mode = M_HOLD; amt = '0; sil = 1'b0; sir = 1'b0; pin = '0;

    vecs[0]  = '{M_LOAD, 3'd0, 1'b0, 1'b0, 8'hA5, 8'hA5};
    vecs[1]  = '{M_SHR,  3'd3, 1'b1, 1'b0, 8'h00, 8'hF4};
    vecs[2]  = '{M_LOAD, 3'd0, 1'b0, 1'b0, 8'h81, 8'h81};
    vecs[3]  = '{M_SAR,  3'd2, 1'b0, 1'b1, 8'h00, 8'hE0};
    vecs[4]  = '{M_SHL,  3'd1, 1'b1, 1'b0, 8'h00, 8'hC0};
    vecs[5]  = '{M_LOAD, 3'd0, 1'b0, 1'b0, 8'h81, 8'h81};
    vecs[6]  = '{M_ROL,  3'd1, 1'b0, 1'b0, 8'h00, ROT ? 8'h03 : 8'h81};
    vecs[7]  = '{M_LOAD, 3'd0, 1'b0, 1'b0, 8'h81, 8'h81};
    vecs[8]  = '{M_ROR,  3'd1, 1'b0, 1'b0, 8'h00, ROT ? 8'hC0 : 8'h81};
    vecs[9]  = '{M_LOAD, 3'd0, 1'b0, 1'b0, 8'h3C, 8'h3C};
    vecs[10] = '{M_SHR,  3'd0, 1'b1, 1'b1, 8'h00, 8'h3C};
    vecs[11] = '{M_SAR,  3'd0, 1'b1, 1'b1, 8'h00, 8'h3C};
    vecs[12] = '{M_HOLD, 3'd5, 1'b1, 1'b1, 8'hFF, 8'h3C};
    vecs[13] = '{M_SHL,  3'd4, 1'b0, 1'b1, 8'h00, 8'hCF};
    vecs[14] = '{M_SAR,  3'd7, 1'b0, 1'b0, 8'h00, 8'hFF};
    vecs[15] = '{M_LOAD, 3'd0, 1'b0, 1'b0, 8'h40, 8'h40};
    vecs[16] = '{M_SAR,  3'd7, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[17] = '{M_SHR,  3'd7, 1'b1, 1'b0, 8'h00, 8'hFE};

    #2;
    check("reset q", 64'(q), 64'h0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sout", 64'(serial_out), 64'd0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      mode = vecs[i].mode; amt = vecs[i].amt; sil = vecs[i].sil;
      sir = vecs[i].sir; pin = vecs[i].pin;
      step();
      check($sformatf("vec%0d q", i), 64'(q), 64'(vecs[i].exp_q));
      check($sformatf("vec%0d sout", i), 64'(serial_out), 64'(vecs[i].exp_q[0]));
      check($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d done", i), 64'(done), 64'd0);
    end

    // Full transfer of 0x96 with a load request held throughout.
    serialize("ser96", 8'h96, W);
    check("ser96 end busy", 64'(busy), 64'd0);
    check("ser96 end done", 64'(done), 64'd0);
    check("ser96 end q", 64'(q), 64'h00);
    step();
    check("ser96 load after", 64'(q), 64'hFF);
    mode = M_HOLD;

    // Abort after three bits; reset acts between clock edges.
    serialize("abort", 8'h96, 3);
    #2 reset_n = 1'b0;
    #1;
    check("abort q", 64'(q), 64'h0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    step();
    #2 reset_n = 1'b1;
    step();
    serialize("restart", 8'h5A, W);
    check("restart end busy", 64'(busy), 64'd0);
    mode = M_HOLD;

    // Randomized traffic against the reference model, starting from reset.
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    mq = '0; bits_left = 0;
    for (int c = 0; c < 400; c++) begin
      mode = 3'($urandom_range(0, 7));
      amt  = 3'($urandom_range(0, 7));
      sil  = 1'($urandom);
      sir  = 1'($urandom);
      pin  = 8'($urandom);
      exp_done = (bits_left == 1);
      check("rnd q", 64'(q), 64'(mq));
      check("rnd busy", 64'(busy), 64'(bits_left > 0));
      check("rnd done", 64'(done), 64'(exp_done));
      if (bits_left > 0) begin
        mq = ref_op(mq, M_SHR, 1, sil, 1'b0);
        bits_left--;
      end else if (mode == M_SER) begin
        mq = pin;
        bits_left = W;
      end else if (mode == M_LOAD) begin
        mq = pin;
      end else begin
        mq = ref_op(mq, mode, int'(amt), sil, sir);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
